// File: rtl/cart_mem_arbiter_pkg.sv
// Shared types and defaults for the cartridge memory-port arbiter.
// Owner and FSM state encodings are common to the top and the grant picker.
package cart_mem_pkg;

  localparam int CART_ADDR_W      = 25;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_LD,
    OWN_CPU,
    OWN_BK
  } owner_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  // Counter width able to hold the value `limit` itself.
  function automatic int starve_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/cart_mem_arbiter_if.sv
// Bundle of the three requester handshakes and the shared memory port.
// The arbiter uses the slave view; the requesters and memory model use master.
interface cart_mem_arbiter_if
  import cart_mem_pkg::*;
#(
  parameter int ADDR_W = CART_ADDR_W
) ();

  logic              ld_req;
  logic              ld_ack;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_din;

  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_ack;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;

  logic              bk_req;
  logic              bk_we;
  logic              bk_ack;
  logic [ADDR_W-1:0] bk_addr;
  logic [7:0]        bk_din;
  logic [7:0]        bk_dout;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic              mem_ack;

  modport slave (
    input  ld_req, ld_addr, ld_din,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  bk_req, bk_we, bk_addr, bk_din,
    input  mem_dout, mem_ack,
    output ld_ack, cpu_ack, cpu_dout, bk_ack, bk_dout,
    output mem_req, mem_we, mem_addr, mem_din
  );

  modport master (
    output ld_req, ld_addr, ld_din,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output bk_req, bk_we, bk_addr, bk_din,
    output mem_dout, mem_ack,
    input  ld_ack, cpu_ack, cpu_dout, bk_ack, bk_dout,
    input  mem_req, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/cart_mem_arbiter_grant.sv
// Combinational winner selection: loader > CPU > backup, with the just-acked
// requester sitting out one decision and backup jumping CPU once starved.
module cart_mem_grant
  import cart_mem_pkg::*;
(
  input  logic   ld_req_i,
  input  logic   cpu_req_i,
  input  logic   bk_req_i,
  input  owner_e cool_i,
  input  logic   starve_hit_i,
  output owner_e win_o
);

  logic ld_ok;
  logic cpu_ok;
  logic bk_ok;

  assign ld_ok  = ld_req_i  && (cool_i != OWN_LD);
  assign cpu_ok = cpu_req_i && (cool_i != OWN_CPU);
  assign bk_ok  = bk_req_i  && (cool_i != OWN_BK);

  always_comb begin
    // NOTE: default assignment first so every path drives win_o and no latch is inferred.
    win_o = OWN_NONE;
    if (ld_ok) begin
      win_o = OWN_LD;
    end else if (bk_ok && starve_hit_i && !ld_req_i) begin
      // A loader still holding its request (even while cooling) blocks the override.
      win_o = OWN_BK;
    end else if (cpu_ok) begin
      win_o = OWN_CPU;
    end else if (bk_ok) begin
      win_o = OWN_BK;
    end
  end

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares the single cartridge memory port among loader, CPU mapper and backup
// engine: registered grant, one-cycle acks and per-requester read-data return.
module cart_mem_arbiter
  import cart_mem_pkg::*;
#(
  parameter int ADDR_W       = CART_ADDR_W,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic               clk,
  input logic               reset,
  cart_mem_arbiter_if.slave bus
);

  localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);

  state_e            state_q;
  owner_e            owner_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_din_q;
  logic              ld_ack_q;
  logic              cpu_ack_q;
  logic              bk_ack_q;
  logic [7:0]        cpu_dout_q;
  logic [7:0]        bk_dout_q;
  logic [CNT_W-1:0]  starve_q;
  logic [CNT_W-1:0]  starve_d;

  owner_e cool;
  owner_e win;
  logic   starve_hit;

  // The requester whose ack is visible this cycle may still show its old request.
  always_comb begin
    cool = OWN_NONE;
    if (ld_ack_q)       cool = OWN_LD;
    else if (cpu_ack_q) cool = OWN_CPU;
    else if (bk_ack_q)  cool = OWN_BK;
  end

  assign starve_hit = (starve_q == CNT_W'(STARVE_LIMIT));

  cart_mem_grant u_grant (
    .ld_req_i     (bus.ld_req),
    .cpu_req_i    (bus.cpu_req),
    .bk_req_i     (bus.bk_req),
    .cool_i       (cool),
    .starve_hit_i (starve_hit),
    .win_o        (win)
  );

  always_comb begin
    starve_d = starve_q;
    if (!bus.bk_req) begin
      starve_d = '0;
    end else if (state_q == ST_IDLE && win == OWN_BK) begin
      starve_d = '0;
    end else if (state_q == ST_IDLE && win == OWN_CPU && !starve_hit) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      ld_ack_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      bk_ack_q   <= 1'b0;
      cpu_dout_q <= 8'h00;
      bk_dout_q  <= 8'h00;
      starve_q   <= '0;
    end else begin
      ld_ack_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      bk_ack_q  <= 1'b0;
      starve_q  <= starve_d;
      case (state_q)
        ST_IDLE: begin
          if (win != OWN_NONE) begin
            state_q   <= ST_BUSY;
            owner_q   <= win;
            mem_req_q <= 1'b1;
            case (win)
              OWN_LD: begin
                mem_we_q   <= 1'b1;
                mem_addr_q <= bus.ld_addr;
                mem_din_q  <= bus.ld_din;
              end
              OWN_CPU: begin
                mem_we_q   <= bus.cpu_we;
                mem_addr_q <= bus.cpu_addr;
                mem_din_q  <= bus.cpu_din;
              end
              default: begin
                mem_we_q   <= bus.bk_we;
                mem_addr_q <= bus.bk_addr;
                mem_din_q  <= bus.bk_din;
              end
            endcase
          end
        end
        ST_BUSY: begin
          if (bus.mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            case (owner_q)
              OWN_LD:  ld_ack_q <= 1'b1;
              OWN_CPU: begin
                cpu_ack_q <= 1'b1;
                if (!mem_we_q) cpu_dout_q <= bus.mem_dout;
              end
              OWN_BK: begin
                bk_ack_q <= 1'b1;
                if (!mem_we_q) bk_dout_q <= bus.mem_dout;
              end
              default: ;
            endcase
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ld_ack   = ld_ack_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.bk_ack   = bk_ack_q;
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.bk_dout  = bk_dout_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Self-checking bench for cart_mem_arbiter: table of single transactions plus
// directed priority, back-to-back, starvation and mid-transaction reset sequences.
module tb_cart_mem_arbiter;
  import cart_mem_pkg::*;

  localparam logic [24:0] LD_A  = 25'h0200000;
  localparam logic [24:0] CPU_A = 25'h0004000;
  localparam logic [24:0] BK_A  = 25'h0100000;

  logic clk;
  logic reset;

  cart_mem_arbiter_if #(.ADDR_W(25)) bus ();

  cart_mem_arbiter #(.ADDR_W(25), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;
  bit mem_auto = 1'b1;
  bit inject_ack = 1'b0;

  // Memory model: acks after mem_lat cycles of mem_req, stores writes, returns stored bytes.
  initial begin
    logic [7:0] store [logic [24:0]];
    int lat_cnt;
    lat_cnt = 0;
    store[CPU_A] = 8'hA5;
    store[BK_A]  = 8'h3C;
    bus.mem_ack  = 1'b0;
    bus.mem_dout = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (inject_ack) begin
        bus.mem_ack  = 1'b1;
        bus.mem_dout = 8'h99;
      end else if (mem_auto && bus.mem_req) begin
        lat_cnt++;
        if (lat_cnt >= mem_lat) begin
          lat_cnt = 0;
          bus.mem_ack = 1'b1;
          if (bus.mem_we) store[bus.mem_addr] = bus.mem_din;
          else bus.mem_dout = store.exists(bus.mem_addr) ? store[bus.mem_addr] : 8'hEE;
        end else begin
          bus.mem_ack = 1'b0;
        end
      end else begin
        lat_cnt = 0;
        bus.mem_ack = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input owner_e w, input logic v, input logic we,
                         input logic [24:0] a, input logic [7:0] d);
    case (w)
      OWN_LD:  begin bus.ld_req = v; bus.ld_addr = a; bus.ld_din = d; end
      OWN_CPU: begin bus.cpu_req = v; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d; end
      OWN_BK:  begin bus.bk_req = v; bus.bk_we = we; bus.bk_addr = a; bus.bk_din = d; end
      default: ;
    endcase
  endtask

  function automatic logic ack_of(input owner_e w);
    case (w)
      OWN_LD:  return bus.ld_ack;
      OWN_CPU: return bus.cpu_ack;
      OWN_BK:  return bus.bk_ack;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ack_count();
    return int'(bus.ld_ack) + int'(bus.cpu_ack) + int'(bus.bk_ack);
  endfunction

  function automatic owner_e owner_of_addr(input logic [24:0] a);
    if (a == LD_A)  return OWN_LD;
    if (a == CPU_A) return OWN_CPU;
    if (a == BK_A)  return OWN_BK;
    return OWN_NONE;
  endfunction

  typedef struct {
    owner_e      who;
    logic        we;
    logic [24:0] addr;
    logic [7:0]  din;
    int          lat;
    logic        exp_we;
    logic [7:0]  exp_cpu;
    logic [7:0]  exp_bk;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int i, input vec_t v);
    int n;
    mem_lat = v.lat;
    set_req(v.who, 1'b1, v.we, v.addr, v.din);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_req && n < 20);
    check($sformatf("v%0d_grant_latency", i), 32'(n), 32'd1);
    check($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(v.exp_we));
    check($sformatf("v%0d_mem_addr", i), 32'(bus.mem_addr), 32'(v.addr));
    if (v.exp_we) check($sformatf("v%0d_mem_din", i), 32'(bus.mem_din), 32'(v.din));
    n = 0;
    do begin @(negedge clk); n++; end while (!ack_of(v.who) && n < 20);
    check($sformatf("v%0d_ack_latency", i), 32'(n), 32'(v.lat));
    check($sformatf("v%0d_mem_req_drop", i), 32'(bus.mem_req), 32'd0);
    check($sformatf("v%0d_single_ack", i), 32'(ack_count()), 32'd1);
    check($sformatf("v%0d_cpu_dout", i), 32'(bus.cpu_dout), 32'(v.exp_cpu));
    check($sformatf("v%0d_bk_dout", i), 32'(bus.bk_dout), 32'(v.exp_bk));
    set_req(v.who, 1'b0, v.we, v.addr, v.din);
    @(negedge clk);
    check($sformatf("v%0d_ack_width", i), 32'(ack_count()), 32'd0);
  endtask

  // All three request together; loader drops its request on its drop_at-th ack.
  task automatic starve_run(input int drop_at, input int exp_cpu, input owner_e exp_prev);
    int     ld_acks;
    int     cpu_before;
    owner_e prev;
    owner_e after;
    owner_e w;
    bit     bk_seen;
    bit     done;
    logic   prev_req;
    ld_acks = 0; cpu_before = 0; prev = OWN_NONE; after = OWN_NONE;
    bk_seen = 1'b0; done = 1'b0; prev_req = 1'b0;
    mem_lat = 1;
    set_req(OWN_LD,  1'b1, 1'b0, LD_A,  8'hC3);
    set_req(OWN_CPU, 1'b1, 1'b0, CPU_A, 8'h00);
    set_req(OWN_BK,  1'b1, 1'b0, BK_A,  8'h00);
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_req && !prev_req) begin
        w = owner_of_addr(bus.mem_addr);
        if (bk_seen) begin
          if (after == OWN_NONE) after = w;
        end else if (w == OWN_BK) begin
          bk_seen = 1'b1;
        end else begin
          prev = w;
          if (w == OWN_CPU) cpu_before++;
        end
      end
      prev_req = bus.mem_req;
      if (bus.ld_ack) begin
        ld_acks++;
        if (ld_acks == drop_at) set_req(OWN_LD, 1'b0, 1'b0, LD_A, 8'hC3);
      end
      if (bus.bk_ack) set_req(OWN_BK, 1'b0, 1'b0, BK_A, 8'h00);
      if (bus.cpu_ack && after == OWN_CPU) begin
        set_req(OWN_CPU, 1'b0, 1'b0, CPU_A, 8'h00);
        done = 1'b1;
      end
    end
    check($sformatf("starve%0d_completed", drop_at), 32'(done), 32'd1);
    check($sformatf("starve%0d_backup_granted", drop_at), 32'(bk_seen), 32'd1);
    check($sformatf("starve%0d_cpu_grants_before_bk", drop_at), 32'(cpu_before), 32'(exp_cpu));
    check($sformatf("starve%0d_grant_before_bk", drop_at), 32'(prev), 32'(exp_prev));
    check($sformatf("starve%0d_grant_after_bk", drop_at), 32'(after), 32'(OWN_CPU));
    if (!done) begin
      set_req(OWN_LD,  1'b0, 1'b0, LD_A,  8'hC3);
      set_req(OWN_CPU, 1'b0, 1'b0, CPU_A, 8'h00);
      set_req(OWN_BK,  1'b0, 1'b0, BK_A,  8'h00);
    end
    repeat (4) @(negedge clk);
    check($sformatf("starve%0d_idle_after", drop_at), 32'(bus.mem_req), 32'd0);
  endtask

  initial begin
    int   n;
    int   grants;
    int   acks;
    int   last_ack;
    logic prev_req;

    vecs[0] = '{OWN_CPU, 1'b0, CPU_A,        8'h00, 2, 1'b0, 8'hA5, 8'h00};
    vecs[1] = '{OWN_BK,  1'b1, BK_A,         8'h3C, 1, 1'b1, 8'hA5, 8'h00};
    vecs[2] = '{OWN_BK,  1'b0, BK_A,         8'h00, 3, 1'b0, 8'hA5, 8'h3C};
    vecs[3] = '{OWN_LD,  1'b0, 25'h1FFFFFF,  8'h5A, 1, 1'b1, 8'hA5, 8'h3C};
    vecs[4] = '{OWN_CPU, 1'b0, 25'h1FFFFFF,  8'h00, 1, 1'b0, 8'h5A, 8'h3C};
    vecs[5] = '{OWN_CPU, 1'b1, 25'h0000000,  8'h77, 2, 1'b1, 8'h5A, 8'h3C};
    vecs[6] = '{OWN_CPU, 1'b0, 25'h0000000,  8'h00, 1, 1'b0, 8'h77, 8'h3C};

    reset = 1'b1;
    set_req(OWN_LD,  1'b0, 1'b0, '0, '0);
    set_req(OWN_CPU, 1'b0, 1'b0, '0, '0);
    set_req(OWN_BK,  1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_mem_req",  32'(bus.mem_req),  32'd0);
    check("rst_mem_we",   32'(bus.mem_we),   32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_din",  32'(bus.mem_din),  32'd0);
    check("rst_acks",     32'(ack_count()),  32'd0);
    check("rst_cpu_dout", 32'(bus.cpu_dout), 32'd0);
    check("rst_bk_dout",  32'(bus.bk_dout),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Loader and CPU raised together: loader first, CPU on the loader's ack cycle.
    mem_lat = 1;
    set_req(OWN_LD,  1'b1, 1'b0, LD_A,  8'hC3);
    set_req(OWN_CPU, 1'b1, 1'b0, CPU_A, 8'h00);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_req && n < 20);
    check("prio_first_addr", 32'(bus.mem_addr), 32'(LD_A));
    check("prio_first_we",   32'(bus.mem_we),   32'd1);
    check("prio_first_din",  32'(bus.mem_din),  32'hC3);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ld_ack && n < 20);
    check("prio_ld_ack", 32'(bus.ld_ack), 32'd1);
    set_req(OWN_LD, 1'b0, 1'b0, LD_A, 8'hC3);
    @(negedge clk);
    check("prio_cpu_next_req",  32'(bus.mem_req),  32'd1);
    check("prio_cpu_next_addr", 32'(bus.mem_addr), 32'(CPU_A));
    check("prio_cpu_next_we",   32'(bus.mem_we),   32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.cpu_ack && n < 20);
    check("prio_cpu_dout", 32'(bus.cpu_dout), 32'hA5);
    set_req(OWN_CPU, 1'b0, 1'b0, CPU_A, 8'h00);
    @(negedge clk);

    // CPU holds its request through three zero-wait reads.
    mem_lat = 1;
    grants = 0; acks = 0; last_ack = 0; prev_req = 1'b0;
    set_req(OWN_CPU, 1'b1, 1'b0, BK_A, 8'h00);
    for (int c = 1; c <= 40 && acks < 3; c++) begin
      @(negedge clk);
      if (bus.mem_req && !prev_req) grants++;
      prev_req = bus.mem_req;
      if (bus.cpu_ack) begin
        acks++;
        check($sformatf("b2b_req_low_on_ack%0d", acks), 32'(bus.mem_req), 32'd0);
        if (acks > 1) check($sformatf("b2b_ack_gap%0d", acks), 32'(c - last_ack), 32'd3);
        last_ack = c;
        if (acks == 3) set_req(OWN_CPU, 1'b0, 1'b0, BK_A, 8'h00);
      end
    end
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_req && !prev_req) grants++;
      prev_req = bus.mem_req;
      if (bus.cpu_ack) acks++;
    end
    check("b2b_grants",   32'(grants),       32'd3);
    check("b2b_acks",     32'(acks),         32'd3);
    check("b2b_cpu_dout", 32'(bus.cpu_dout), 32'h3C);

    starve_run(8,  8, OWN_CPU);
    starve_run(9,  8, OWN_LD);
    starve_run(10, 9, OWN_LD);

    // Reset while BUSY, then a stray mem_ack that must be ignored.
    mem_auto = 1'b0;
    set_req(OWN_CPU, 1'b1, 1'b0, CPU_A, 8'h00);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_req && n < 20);
    check("rstbusy_req_before", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rstbusy_mem_req",  32'(bus.mem_req),  32'd0);
    check("rstbusy_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rstbusy_acks",     32'(ack_count()),  32'd0);
    check("rstbusy_cpu_dout", 32'(bus.cpu_dout), 32'd0);
    reset = 1'b0;
    set_req(OWN_CPU, 1'b0, 1'b0, CPU_A, 8'h00);
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n += ack_count() + int'(bus.mem_req);
    end
    check("late_ack_no_activity", 32'(n),            32'd0);
    check("late_ack_cpu_dout",    32'(bus.cpu_dout), 32'd0);
    check("late_ack_bk_dout",     32'(bus.bk_dout),  32'd0);
    mem_auto = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
